elevator_call_scheduler: RTL and testbench

Upstream stage of elevator_design. Latches floor-call pulses into a pending bitmap and picks the next target floor using SCAN (keep direction while calls remain ahead). Drives the up/down/inf command inputs of elevator_design and consumes its outfloor as position feedback. On arrival it holds a door-dwell interval, clears the serviced call, then schedules the next call.

---
 rtl/elevator_pkg.sv | 35 +++
 rtl/elevator_target_select.sv | 66 ++++++
 rtl/elevator_call_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator blocks: floor codes, controller state
// encoding and travel-direction encoding. elevator_design uses these as well.
package elevator_pkg;

    localparam int FLOOR_COUNT = 8;
    localparam int FLOOR_W     = 3;

    typedef logic [FLOOR_W-1:0] floor_t;

    localparam floor_t F0 = 3'd0;
    localparam floor_t F1 = 3'd1;
    localparam floor_t F2 = 3'd2;
    localparam floor_t F3 = 3'd3;
    localparam floor_t F4 = 3'd4;
    localparam floor_t F5 = 3'd5;
    localparam floor_t F6 = 3'd6;
    localparam floor_t F7 = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // One-hot bitmap with only the bit for floor f set.
    function automatic logic [FLOOR_COUNT-1:0] floor_onehot(input floor_t f);
        return {{(FLOOR_COUNT-1){1'b0}}, 1'b1} << f;
    endfunction

endpackage

// File: rtl/elevator_target_select.sv
// SCAN target search: given the pending bitmap, the current floor and the
// current direction, return the nearest pending floor ahead, or, when none
// is ahead, the nearest floor behind together with the reversed direction.
// The current floor itself is never returned; the caller handles it.
module elevator_target_select
    import elevator_pkg::*;
(
    input  logic [FLOOR_COUNT-1:0] pending,
    input  floor_t                 cur_floor,
    input  dir_t                   dir,
    output logic                   found,
    output floor_t                 target,
    output dir_t                   new_dir
);

    logic [FLOOR_COUNT-1:0] above;
    logic [FLOOR_COUNT-1:0] below;
    floor_t                 lo_above;
    floor_t                 hi_below;

    // Split the pending calls into those strictly above and strictly below.
    genvar gi;
    generate
        for (gi = 0; gi < FLOOR_COUNT; gi++) begin : g_split
            assign above[gi] = pending[gi] && (floor_t'(gi) > cur_floor);
            assign below[gi] = pending[gi] && (floor_t'(gi) < cur_floor);
        end
    endgenerate

    // Nearest call above (lowest set bit) and nearest call below (highest set bit).
    always_comb begin
        lo_above = cur_floor;
        hi_below = cur_floor;
        for (int i = FLOOR_COUNT - 1; i >= 0; i--) begin
            if (above[i]) lo_above = floor_t'(i);
        end
        for (int i = 0; i < FLOOR_COUNT; i++) begin
            if (below[i]) hi_below = floor_t'(i);
        end
    end

    // Keep the current direction while anything lies ahead, otherwise reverse.
    always_comb begin
        found   = |(above | below);
        target  = cur_floor;
        new_dir = dir;
        if (dir == DIR_UP) begin
            if (|above) begin
                target  = lo_above;
                new_dir = DIR_UP;
            end else if (|below) begin
                target  = hi_below;
                new_dir = DIR_DOWN;
            end
        end else begin
            if (|below) begin
                target  = hi_below;
                new_dir = DIR_DOWN;
            end else if (|above) begin
                target  = lo_above;
                new_dir = DIR_UP;
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: latches call pulses into a pending bitmap, picks
// targets with SCAN, drives up/down/inf towards elevator_design, and holds a
// door dwell at each stop. All outputs are registered.
// Optional build macro ELEV_SCHED_FIRE_RECALL_EN adds the fire_recall input
// (send the car to floor 0 and hold the door open while it stays high).
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ELEV_SCHED_FIRE_RECALL_EN
    input  logic                  fire_recall,
`endif
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [2:0]            cur_floor,
    output logic                  up,
    output logic                  down,
    output logic [2:0]            inf,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES - 1);

    state_t                  state_reg, state_next;
    dir_t                    dir_reg, dir_next;
    logic [NUM_FLOORS-1:0]   pending_reg, pending_next;
    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [7:0]              cnt_reg, cnt_next;
    logic                    up_reg, up_next;
    logic                    down_reg, down_next;
    floor_t                  inf_reg, inf_next;
    logic                    door_reg, door_next;
    logic                    busy_reg, busy_next;
`ifdef ELEV_SCHED_FIRE_RECALL_EN
    logic                    fire_reg;
`endif

    logic                    sel_found;
    floor_t                  sel_target;
    dir_t                    sel_dir;
    logic                    at_cur;
    logic                    call_at_cur;
    logic                    arrived;
    logic                    retarget;

    elevator_target_select u_target_select (
        .pending   (pending_reg),
        .cur_floor (cur_floor),
        .dir       (dir_reg),
        .found     (sel_found),
        .target    (sel_target),
        .new_dir   (sel_dir)
    );

    assign at_cur      = pending_reg[cur_floor];
    assign call_at_cur = call_req[cur_floor];
    assign arrived     = (cur_floor == inf_reg);
    // A call strictly between here and the current target, in the travel direction.
    assign retarget    = sel_found && (sel_dir == dir_reg) &&
                         ((dir_reg == DIR_UP) ? (sel_target < inf_reg)
                                              : (sel_target > inf_reg));

    // State, call bitmap, dwell counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            dir_reg     <= DIR_UP;
            pending_reg <= '0;
            cnt_reg     <= '0;
            up_reg      <= 1'b0;
            down_reg    <= 1'b0;
            inf_reg     <= F0;
            door_reg    <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef ELEV_SCHED_FIRE_RECALL_EN
            fire_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            up_reg      <= up_next;
            down_reg    <= down_next;
            inf_reg     <= inf_next;
            door_reg    <= door_next;
            busy_reg    <= busy_next;
`ifdef ELEV_SCHED_FIRE_RECALL_EN
            fire_reg    <= fire_recall;
`endif
        end
    end

    // Next state, direction, dwell count and call bitmap.
    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        cnt_next   = cnt_reg;
        clear_mask = '0;
        case (state_reg)
            IDLE: begin
                if (at_cur) begin
                    state_next = DOOR;
                    cnt_next   = DOOR_LOAD;
                    clear_mask = floor_onehot(cur_floor);
                end else if (sel_found) begin
                    state_next = MOVE;
                    dir_next   = sel_dir;
                end
            end
            MOVE: begin
                if (arrived) begin
                    state_next = DOOR;
                    cnt_next   = DOOR_LOAD;
                    clear_mask = floor_onehot(inf_reg);
                end
            end
            DOOR: begin
                // A repeat call for this floor is absorbed and restarts the dwell.
                clear_mask = floor_onehot(cur_floor);
                if (call_at_cur) begin
                    cnt_next = DOOR_LOAD;
                end else if (cnt_reg == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        pending_next = (pending_reg | call_req) & ~clear_mask;
`ifdef ELEV_SCHED_FIRE_RECALL_EN
        if (fire_recall) begin
            pending_next = '0;
            dir_next     = DIR_DOWN;
            cnt_next     = '0;
            state_next   = (cur_floor == F0) ? DOOR : MOVE;
        end else if (fire_reg) begin
            pending_next = call_req;
            dir_next     = DIR_UP;
            cnt_next     = '0;
            state_next   = IDLE;
        end
`endif
    end

    // Next values of the registered command outputs.
    always_comb begin
        up_next   = up_reg;
        down_next = down_reg;
        inf_next  = inf_reg;
        door_next = door_reg;
        case (state_reg)
            IDLE: begin
                up_next   = 1'b0;
                down_next = 1'b0;
                door_next = 1'b0;
                if (at_cur) begin
                    door_next = 1'b1;
                end else if (sel_found) begin
                    inf_next  = sel_target;
                    up_next   = (sel_target > cur_floor);
                    down_next = ~(sel_target > cur_floor);
                end
            end
            MOVE: begin
                if (arrived) begin
                    up_next   = 1'b0;
                    down_next = 1'b0;
                    door_next = 1'b1;
                end else if (retarget) begin
                    inf_next = sel_target;
                end
            end
            DOOR: begin
                up_next   = 1'b0;
                down_next = 1'b0;
                door_next = (state_next == DOOR);
            end
            default: begin
                up_next   = 1'b0;
                down_next = 1'b0;
                door_next = 1'b0;
            end
        endcase
`ifdef ELEV_SCHED_FIRE_RECALL_EN
        if (fire_recall) begin
            up_next   = 1'b0;
            inf_next  = F0;
            down_next = (cur_floor != F0);
            door_next = (cur_floor == F0);
        end else if (fire_reg) begin
            up_next   = 1'b0;
            down_next = 1'b0;
            door_next = 1'b0;
        end
`endif
        busy_next = (state_next != IDLE);
    end

    assign up        = up_reg;
    assign down      = down_reg;
    assign inf       = inf_reg;
    assign door_open = door_reg;
    assign pending   = pending_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler (DOOR_CYCLES = 4). The bench
// plays the part of elevator_design by driving cur_floor directly.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_elevator_call_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] call_req;
    logic [2:0] cur_floor;
    logic       up;
    logic       down;
    logic [2:0] inf;
    logic       door_open;
    logic [7:0] pending;
    logic       busy;
`ifdef ELEV_SCHED_FIRE_RECALL_EN
    logic       fire_recall;
`endif

    int checks = 0;
    int errors = 0;

    elevator_call_scheduler #(
        .NUM_FLOORS  (8),
        .DOOR_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef ELEV_SCHED_FIRE_RECALL_EN
        .fire_recall (fire_recall),
`endif
        .call_req    (call_req),
        .cur_floor   (cur_floor),
        .up          (up),
        .down        (down),
        .inf         (inf),
        .door_open   (door_open),
        .pending     (pending),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After the edge that opened the door: three more open cycles, then closed and idle.
    task automatic dwell_out(input string tag);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "_door_hold"}, 8'(door_open), 8'd1);
        end
        tick();
        chk({tag, "_door_close"}, 8'(door_open), 8'd0);
        chk({tag, "_idle"}, 8'(busy), 8'd0);
    endtask

    task automatic pulse(input logic [7:0] calls);
        call_req = calls;
        tick();
        call_req = 8'h00;
    endtask

    initial begin
        rst       = 1'b0;
        call_req  = 8'h00;
        cur_floor = 3'd0;
`ifdef ELEV_SCHED_FIRE_RECALL_EN
        fire_recall = 1'b0;
`endif
        tick();
        tick();
        chk("rst_cmd", {4'd0, up, down, door_open, busy}, 8'h00);
        chk("rst_inf", 8'(inf), 8'd0);
        chk("rst_pending", pending, 8'h00);
        rst = 1'b1;
        tick();

        // Single call for floor 3 from floor 0.
        pulse(8'h08);
        chk("t1_pending", pending, 8'h08);
        chk("t1_not_yet", 8'(up), 8'd0);
        tick();
        chk("t1_up", {6'd0, up, down}, 8'b10);
        chk("t1_inf", 8'(inf), 8'd3);
        chk("t1_busy", 8'(busy), 8'd1);
        cur_floor = 3'd1;
        tick();
        chk("t1_moving", 8'(up), 8'd1);
        cur_floor = 3'd3;
        tick();
        chk("t1_arrive_door", 8'(door_open), 8'd1);
        chk("t1_arrive_cmd", {6'd0, up, down}, 8'b00);
        chk("t1_cleared", pending, 8'h00);
        dwell_out("t1");

        // Call below with dir UP: SCAN reverses, go down to floor 0.
        pulse(8'h01);
        tick();
        chk("t2_down", {6'd0, up, down}, 8'b01);
        chk("t2_down_inf", 8'(inf), 8'd0);
        cur_floor = 3'd0;
        tick();
        chk("t2_at0_door", 8'(door_open), 8'd1);
        dwell_out("t2a");

        // From floor 0: call 6, then 2 arrives mid-move and becomes the target.
        pulse(8'h40);
        tick();
        chk("t2_up6", {6'd0, up, down}, 8'b10);
        chk("t2_inf6", 8'(inf), 8'd6);
        cur_floor = 3'd1;
        pulse(8'h04);
        chk("t2_pending", pending, 8'h44);
        tick();
        chk("t2_retarget", 8'(inf), 8'd2);
        chk("t2_still_up", {6'd0, up, down}, 8'b10);
        cur_floor = 3'd2;
        tick();
        chk("t2_stop2_door", 8'(door_open), 8'd1);
        chk("t2_stop2_pending", pending, 8'h40);
        dwell_out("t2b");
        tick();
        chk("t2_resume_up", {6'd0, up, down}, 8'b10);
        chk("t2_resume_inf", 8'(inf), 8'd6);
        cur_floor = 3'd6;
        tick();
        chk("t2_stop6_door", 8'(door_open), 8'd1);
        dwell_out("t2c");

        // At floor 4 with dir UP: calls 1 and 6 together, 6 served first.
        cur_floor = 3'd4;
        pulse(8'h42);
        tick();
        chk("t3_up6", {6'd0, up, down}, 8'b10);
        chk("t3_inf6", 8'(inf), 8'd6);
        cur_floor = 3'd6;
        tick();
        chk("t3_stop6_pending", pending, 8'h02);
        dwell_out("t3a");
        tick();
        chk("t3_down1", {6'd0, up, down}, 8'b01);
        chk("t3_inf1", 8'(inf), 8'd1);
        cur_floor = 3'd1;
        tick();
        chk("t3_stop1_door", 8'(door_open), 8'd1);
        dwell_out("t3b");

        // Call at the current floor while idle; repeated call in dwell cycle 3.
        cur_floor = 3'd5;
        pulse(8'h20);
        chk("t4_pending", pending, 8'h20);
        tick();
        chk("t4_door", 8'(door_open), 8'd1);
        chk("t4_no_move", {6'd0, up, down}, 8'b00);
        chk("t4_cleared", pending, 8'h00);
        tick();
        chk("t4_cycle2", 8'(door_open), 8'd1);
        pulse(8'h20);
        chk("t4_absorbed", pending, 8'h00);
        chk("t4_cycle3", 8'(door_open), 8'd1);
        dwell_out("t4");

        // Asynchronous reset in the middle of a move.
        cur_floor = 3'd0;
        pulse(8'hA0);
        tick();
        chk("t5_pending", pending, 8'hA0);
        chk("t5_moving", {6'd0, up, down}, 8'b10);
        chk("t5_inf", 8'(inf), 8'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_cmd", {6'd0, up, down}, 8'b00);
        chk("t5_rst_pending", pending, 8'h00);
        chk("t5_rst_busy", 8'(busy), 8'd0);
        rst = 1'b1;
        tick();
        chk("t5_after_idle", {4'd0, up, down, door_open, busy}, 8'h00);

`ifdef ELEV_SCHED_FIRE_RECALL_EN
        // Fire recall preempts a move up to 7 and sends the car to floor 0.
        cur_floor = 3'd5;
        pulse(8'h80);
        tick();
        chk("f_up7", {6'd0, up, down}, 8'b10);
        chk("f_inf7", 8'(inf), 8'd7);
        fire_recall = 1'b1;
        call_req    = 8'h04;
        tick();
        call_req = 8'h00;
        chk("f_down", {6'd0, up, down}, 8'b01);
        chk("f_inf0", 8'(inf), 8'd0);
        chk("f_pending", pending, 8'h00);
        chk("f_busy", 8'(busy), 8'd1);
        cur_floor = 3'd3;
        tick();
        chk("f_still_down", {6'd0, up, down}, 8'b01);
        cur_floor = 3'd0;
        tick();
        chk("f_at0_door", 8'(door_open), 8'd1);
        chk("f_at0_cmd", {6'd0, up, down}, 8'b00);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("f_door_held", 8'(door_open), 8'd1);
        end
        fire_recall = 1'b0;
        tick();
        chk("f_release_door", 8'(door_open), 8'd0);
        chk("f_release_busy", 8'(busy), 8'd0);
        cur_floor = 3'd4;
        pulse(8'h44);
        tick();
        chk("f_dir_up", {6'd0, up, down}, 8'b10);
        chk("f_dir_up_inf", 8'(inf), 8'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
